cacheline_adaptor: RTL and testbench
====================================

// Module: cacheline_adaptor
// PURPOSE
//  Memory-side responder for the cache's pmem_* line interface. Accepts one 256-bit line
//  read or write request and carries it out as a 4-beat, 64-bit burst on the physical
//  memory bus. Returns pmem_resp when the line transfer is complete.
//  Sits between cache (or arbiter) and the burst DRAM model/controller.
// PARAMETERS
//  LINE_WIDTH   256  cache line width in bits
//  BURST_WIDTH  64   memory data bus width in bits
//  BEATS        LINE_WIDTH/BURST_WIDTH (4)  beats per line; localparam, must be a power of 2
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous, active-high reset
//  pmem_read     in   1    line read request from cache; held until pmem_resp
//  pmem_write    in   1    line write request from cache; held until pmem_resp
//  pmem_address  in   32   line address
//  pmem_wdata    in   256  line to write
//  pmem_rdata    out  256  assembled read line
//  pmem_resp     out  1    one-cycle completion pulse
//  burst_i       in   64   read beat from memory
//  burst_o       out  64   write beat to memory
//  address_o     out  32   burst address, latched at accept
//  read_o        out  1    burst read request
//  write_o       out  1    burst write request
//  resp_i        in   1    memory beat strobe; one beat per high cycle
// BEHAVIOUR
//  - Reset: state IDLE, beat count 0, and all outputs 0: pmem_resp, read_o, write_o,
//    burst_o, address_o and pmem_rdata.
//  - FSM states: IDLE -> RD | WR -> DONE -> IDLE.
//  - IDLE:
//    - Sample requests only in IDLE. pmem_write has priority if both are high.
//    - On accept: latch the address into address_o, latch pmem_wdata for a write,
//      clear the beat counter.
//    - Enter RD (read_o=1) or WR (write_o=1) the next cycle.
//    - resp_i in IDLE or DONE is ignored.
//  - RD:
//    - read_o stays high for the whole state.
//    - Each resp_i cycle stores burst_i into pmem_rdata[64k+:64], where k is the beat
//      count, then increments k.
//    - resp_i may stall between beats (gaps allowed).
//    - On the 4th beat (k==3), go to DONE and drop read_o the next cycle.
//  - WR:
//    - write_o stays high for the whole state.
//    - burst_o = wdata_latched[64k+:64], lowest beat first.
//    - On resp_i the beat is consumed and k increments.
//    - On the 4th beat, go to DONE and drop write_o.
//  - DONE:
//    - pmem_resp=1 for exactly one cycle, then IDLE.
//    - Minimum latency from accept to pmem_resp = 1 + BEATS + 1 cycles.
//  - pmem_rdata holds its last assembled line until the next read's beats overwrite it.
//  - Request or address changes mid-transaction are ignored (latched values are used).
//    The cache must drop its request the cycle after pmem_resp, otherwise a new
//    transaction starts from IDLE.
//  - Beat counter is log2(BEATS) bits and wraps to 0 after the last beat.
//  - rst mid-burst: return to IDLE immediately and clear read_o/write_o. The partial
//    line is discarded and no pmem_resp is issued. The memory side must also be reset.
// CONFIGURATION
//  ADAPTOR_LINE_ALIGN_EN
//   defined:   address_o = {pmem_address[31:5], 5'b0}, forcing line-aligned bursts.
//   undefined: address_o = pmem_address, passed through unmodified.
// TESTING
//  1. Read 0x0000_1040; memory returns beats 0x11..,0x22..,0x33..,0x44.. on consecutive
//     resp_i -> pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, pmem_resp 1 cycle, 6 cycles total.
//  2. Write line {D3,D2,D1,D0} -> burst_o = D0,D1,D2,D3 on successive resp_i;
//     write_o drops after D3; single pmem_resp.
//  3. Read with resp_i gaps (beats at cycles 2,5,6,9) -> correct line, pmem_resp one
//     cycle after cycle 9.
//  4. pmem_read and pmem_write both high -> write burst performed, read_o never asserted.
//  5. rst asserted after beat 2 of a read -> next cycle all outputs 0, no pmem_resp;
//     a new read completes correctly.
//  6. Address 0x0000_105C with ADAPTOR_LINE_ALIGN_EN -> address_o = 0x0000_1040;
//     without it -> 0x0000_105C.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Line-request and burst-bus signals around cacheline_adaptor.
// slave = adaptor view; master = cache plus burst-memory environment.
interface cacheline_adaptor_if #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64
);
    logic                   pmem_read;
    logic                   pmem_write;
    logic [31:0]            pmem_address;
    logic [LINE_WIDTH-1:0]  pmem_wdata;
    logic [LINE_WIDTH-1:0]  pmem_rdata;
    logic                   pmem_resp;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
        output pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
        input  pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache line read/write request into a BEATS-beat burst on the memory bus.
// Optional macro ADAPTOR_LINE_ALIGN_EN forces address_o to a line-aligned address.
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64
) (
    input logic               clk,
    input logic               rst,
    cacheline_adaptor_if.slave bus
);
    localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;
    logic [BURST_WIDTH-1:0] beat_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.pmem_write || bus.pmem_read) begin
`ifdef ADAPTOR_LINE_ALIGN_EN
                    addr_d = {bus.pmem_address[31:OFF_W], OFF_W'(0)};
`else
                    addr_d = bus.pmem_address;
`endif
                    cnt_d = '0;
                    if (bus.pmem_write) begin
                        wdata_d = bus.pmem_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (bus.resp_i) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            rdata_d[b*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WR: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write beat is driven only in WR so burst_o reads 0 whenever the bus is idle.
    always_comb begin
        beat_out = '0;
        if (state_q == WR) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) beat_out = wdata_q[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    assign bus.read_o     = (state_q == RD);
    assign bus.write_o    = (state_q == WR);
    assign bus.pmem_resp  = (state_q == DONE);
    assign bus.burst_o    = beat_out;
    assign bus.address_o  = addr_q;
    assign bus.pmem_rdata = rdata_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: the bench plays both cache and burst memory
// and compares every cycle against a line-level transaction model.
module tb_cacheline_adaptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [255:0] last_rdata = '0;

    always #5 clk = ~clk;

    cacheline_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64)) bus ();

    cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef ADAPTOR_LINE_ALIGN_EN
        return a & 32'hFFFF_FFE0;
`else
        return a;
`endif
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".read_o"},  bus.read_o, 0);
        check({tag, ".write_o"}, bus.write_o, 0);
        check({tag, ".resp"},    bus.pmem_resp, 0);
        check({tag, ".burst_o"}, bus.burst_o, 0);
    endtask

    // One line transaction; gaps holds the idle cycles before each beat (4 bits per beat).
    task automatic run_txn(input string tag, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [255:0] wdata,
                           input logic [15:0] gaps);
        logic [255:0] exp_line;
        logic [63:0]  beat;
        int unsigned  g;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wdata;
        bus.resp_i       = 1'b0;
        bus.burst_i      = {$urandom, $urandom};
        @(negedge clk);
        check({tag, ".req_on"},   wr ? bus.write_o : bus.read_o, 1);
        check({tag, ".req_off"},  wr ? bus.read_o : bus.write_o, 0);
        check({tag, ".address"},  bus.address_o, exp_addr(addr));
        // Scramble the held inputs: the adaptor must use its latched copies.
        bus.pmem_address = $urandom;
        bus.pmem_wdata   = rand_line();
        exp_line = last_rdata;
        for (int k = 0; k < 4; k++) begin
            g = gaps[4*k +: 4];
            repeat (g) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = {$urandom, $urandom};
                check({tag, ".gap_busy"}, wr ? bus.write_o : bus.read_o, 1);
                check({tag, ".gap_resp"}, bus.pmem_resp, 0);
                if (wr) check({tag, ".gap_burst"}, bus.burst_o, {192'b0, wdata[64*k +: 64]});
                @(negedge clk);
            end
            bus.resp_i = 1'b1;
            if (wr) begin
                check({tag, ".burst_o"}, bus.burst_o, {192'b0, wdata[64*k +: 64]});
                check({tag, ".no_read"}, bus.read_o, 0);
            end else begin
                beat = {$urandom, $urandom};
                bus.burst_i = beat;
                exp_line[64*k +: 64] = beat;
            end
            check({tag, ".beat_resp"}, bus.pmem_resp, 0);
            @(negedge clk);
        end
        bus.resp_i = 1'b0;
        if (!wr) last_rdata = exp_line;
        check({tag, ".done_resp"},  bus.pmem_resp, 1);
        check({tag, ".done_rd"},    bus.read_o, 0);
        check({tag, ".done_wr"},    bus.write_o, 0);
        check({tag, ".rdata"},      bus.pmem_rdata, last_rdata);
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        @(negedge clk);
        check_idle({tag, ".after"});
        check({tag, ".rdata_hold"}, bus.pmem_rdata, last_rdata);
    endtask

    task automatic reset_mid_read();
        bus.pmem_read    = 1'b1;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 32'h0000_2000;
        bus.resp_i       = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        bus.resp_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.pmem_read = 1'b0;
        last_rdata = '0;
        check_idle("rst_mid");
        check("rst_mid.address", bus.address_o, 0);
        check("rst_mid.rdata",   bus.pmem_rdata, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid.no_resp", bus.pmem_resp, 0);
        end
    endtask

    initial begin
        logic [15:0] gaps;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.burst_i      = '0;
        bus.resp_i       = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset.address", bus.address_o, 0);
        check("reset.rdata",   bus.pmem_rdata, 0);
        rst = 1'b0;
        bus.resp_i = 1'b0;
        @(negedge clk);
        // resp_i strobes while idle must not start or advance anything
        bus.resp_i = 1'b1;
        @(negedge clk);
        check_idle("idle_resp");
        bus.resp_i = 1'b0;

        run_txn("rd_back2back", 1'b1, 1'b0, 32'h0000_1040, '0, 16'h0000);
        run_txn("wr_line",      1'b0, 1'b1, 32'h0000_3000, rand_line(), 16'h0000);
        run_txn("rd_gaps",      1'b1, 1'b0, 32'h0000_1080, '0, 16'h2021);
        run_txn("rd_wr_both",   1'b1, 1'b1, 32'h0000_4020, rand_line(), 16'h1010);
        run_txn("addr_105c",    1'b1, 1'b0, 32'h0000_105C, '0, 16'h0000);
        reset_mid_read();
        run_txn("rd_after_rst", 1'b1, 1'b0, 32'h0000_2000, '0, 16'h0100);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 4; k++) gaps[4*k +: 4] = 4'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       run_txn("rnd_rd",   1'b1, 1'b0, $urandom, '0, gaps);
                1:       run_txn("rnd_wr",   1'b0, 1'b1, $urandom, rand_line(), gaps);
                default: run_txn("rnd_both", 1'b1, 1'b1, $urandom, rand_line(), gaps);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
